// File: rtl/evt_stream_rx_pkg.sv
// Shared definitions for the serial event-dump receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package evt_stream_rx_pkg;

   localparam int WORD_W = 12;               // bits per serial word
   localparam int BYTE_W = 8;                // UART buffer byte width
   localparam int CNT_W  = 15;               // word-count / counter width
   localparam logic [3:0] PAD_NIB = 4'b0000; // fills the low nibble of an odd trailing byte

   // One-hot receiver states
   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_SHFT = 3'b010,
      ST_FLSH = 3'b100
   } state_e;

endpackage

// File: rtl/evt_word_packer.sv
// Packs 12-bit words into bytes, 2 words -> 3 bytes, with a padded tail byte on flush.
// Latency: first byte of a word 1 cycle after word_vld; the second word's low byte 1 cycle later.
// Backpressure: none; upstream word spacing (>= 3 cycles) keeps at most 2 bytes pending.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   word_dat/word_vld   12-bit word in with 1-cycle strobe
//   flush               request to emit a held odd nibble as a padded byte
//   byte_dat/byte_vld   byte out with 1-cycle strobe
//   empty               no held nibble and no pending byte
module evt_word_packer
   import evt_stream_rx_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] word_dat,
   input  logic              word_vld,
   input  logic              flush,
   output logic [BYTE_W-1:0] byte_dat,
   output logic              byte_vld,
   output logic              empty
);

   logic              phase_q, phase_d;       // 1: low nibble of word A held
   logic [3:0]        nib_q, nib_d;
   logic              pend_q, pend_d;         // low byte of word B still to send
   logic [BYTE_W-1:0] pend_dat_q, pend_dat_d;
   logic [BYTE_W-1:0] byte_dat_q, byte_dat_d;
   logic              byte_vld_q, byte_vld_d;

   always_comb begin
      phase_d    = phase_q;
      nib_d      = nib_q;
      pend_d     = pend_q;
      pend_dat_d = pend_dat_q;
      byte_dat_d = byte_dat_q;
      byte_vld_d = 1'b0;
      if (word_vld) begin
         byte_vld_d = 1'b1;
         if (!phase_q) begin
            byte_dat_d = word_dat[11:4];
            nib_d      = word_dat[3:0];
            phase_d    = 1'b1;
         end else begin
            byte_dat_d = {nib_q, word_dat[11:8]};
            pend_dat_d = word_dat[7:0];
            pend_d     = 1'b1;
            phase_d    = 1'b0;
         end
      end else if (pend_q) begin
         byte_dat_d = pend_dat_q;
         byte_vld_d = 1'b1;
         pend_d     = 1'b0;
      end else if (flush && phase_q) begin
         byte_dat_d = {nib_q, PAD_NIB};
         byte_vld_d = 1'b1;
         phase_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= 1'b0;
         nib_q      <= '0;
         pend_q     <= 1'b0;
         pend_dat_q <= '0;
         byte_dat_q <= '0;
         byte_vld_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         nib_q      <= nib_d;
         pend_q     <= pend_d;
         pend_dat_q <= pend_dat_d;
         byte_dat_q <= byte_dat_d;
         byte_vld_q <= byte_vld_d;
      end
   end

   assign byte_dat = byte_dat_q;
   assign byte_vld = byte_vld_q;
   assign empty    = !phase_q && !pend_q;

endmodule

// File: rtl/evt_stream_rx.sv
// Deserializes the MSB-first 12-bit event word stream and packs words into UART bytes.
// Latency: WordStrb 1 cycle after a word's last bit; bytes 1-2 cycles after the word strobe.
// Backpressure: none; the stream is continuous and Start is ignored while Busy.
// Ports:
//   Clock, Reset        clock, async active-low reset
//   Start, NWords       start pulse (cycle before first bit) and word count sampled with it
//   SerialIn            serial data, one bit per cycle
//   WordOut/WordStrb    last completed word and its strobe
//   ByteOut/ByteStrb    packed byte and its strobe
//   Busy, Done          transfer in progress / 1-cycle completion pulse
module evt_stream_rx
   import evt_stream_rx_pkg::*;
#(
   parameter int WW = WORD_W,
   parameter int NW = CNT_W
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [NW-1:0]     NWords,
   input  logic              SerialIn,
   output logic [WW-1:0]     WordOut,
   output logic              WordStrb,
   output logic [BYTE_W-1:0] ByteOut,
   output logic              ByteStrb,
   output logic              Busy,
   output logic              Done
);

   localparam int BCW = $clog2(WW);

   state_e          state_q, state_d;
   logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [NW-1:0]   wrd_cnt_q, wrd_cnt_d;
   logic [NW-1:0]   nwords_q, nwords_d;
   logic [WW-2:0]   shreg_q, shreg_d;
   logic [WW-1:0]   word_q, word_d;
   logic            word_strb_q, word_strb_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pk_empty;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      wrd_cnt_d   = wrd_cnt_q;
      nwords_d    = nwords_q;
      shreg_d     = shreg_q;
      word_d      = word_q;
      word_strb_d = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               if (NWords != '0) begin
                  state_d   = ST_SHFT;
                  nwords_d  = NWords;
                  bit_cnt_d = '0;
                  wrd_cnt_d = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_SHFT: begin
            shreg_d = {shreg_q[WW-3:0], SerialIn};
            if (bit_cnt_q == BCW'(WW - 1)) begin
               word_d      = {shreg_q, SerialIn};
               word_strb_d = 1'b1;
               bit_cnt_d   = '0;
               wrd_cnt_d   = wrd_cnt_q + 1'b1;
               if (wrd_cnt_q + 1'b1 == nwords_q) state_d = ST_FLSH;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         ST_FLSH: begin
            // The final word strobe reaches the packer in the first Flsh cycle,
            // so the packer's empty flag only counts once that strobe is gone.
            if (pk_empty && !word_strb_q) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         wrd_cnt_q   <= '0;
         nwords_q    <= '0;
         shreg_q     <= '0;
         word_q      <= '0;
         word_strb_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         wrd_cnt_q   <= wrd_cnt_d;
         nwords_q    <= nwords_d;
         shreg_q     <= shreg_d;
         word_q      <= word_d;
         word_strb_q <= word_strb_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   evt_word_packer u_packer (
      .clk      (Clock),
      .rst_n    (Reset),
      .word_dat (word_q),
      .word_vld (word_strb_q),
      .flush    (state_q == ST_FLSH),
      .byte_dat (ByteOut),
      .byte_vld (ByteStrb),
      .empty    (pk_empty)
   );

   assign WordOut  = word_q;
   assign WordStrb = word_strb_q;
   assign Busy     = busy_q;
   assign Done     = done_q;

endmodule

// File: tb/tb_evt_stream_rx.sv
// Self-checking bench for evt_stream_rx: cycle-indexed stimulus and expectation tables.
// Latency: n/a.
// Backpressure: n/a.
module tb_evt_stream_rx;

   localparam int NCYC = 1500;
   localparam int ENDC = 1430;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic [14:0] NWords;
   logic        SerialIn;
   logic [11:0] WordOut;
   logic        WordStrb;
   logic [7:0]  ByteOut;
   logic        ByteStrb;
   logic        Busy;
   logic        Done;

   evt_stream_rx dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .NWords   (NWords),
      .SerialIn (SerialIn),
      .WordOut  (WordOut),
      .WordStrb (WordStrb),
      .ByteOut  (ByteOut),
      .ByteStrb (ByteStrb),
      .Busy     (Busy),
      .Done     (Done)
   );

   // stimulus tables, indexed by cycle
   bit        rst_arr   [0:NCYC-1];
   bit        start_arr [0:NCYC-1];
   bit [14:0] nw_arr    [0:NCYC-1];
   bit        ser_arr   [0:NCYC-1];
   // expectation tables, indexed by cycle
   bit        exp_ws    [0:NCYC-1];
   bit [11:0] exp_wd    [0:NCYC-1];
   bit        exp_bs    [0:NCYC-1];
   bit [7:0]  exp_bd    [0:NCYC-1];
   bit        exp_busy  [0:NCYC-1];
   bit        exp_done  [0:NCYC-1];

   logic [11:0] wq [$];
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int t6_words = 0;
   int t6_bytes = 0;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // Model of one transfer started in cycle t with the words in wq:
   // word k's bits occupy cycles t+1+12k .. t+12+12k, its strobe follows one cycle later,
   // bytes follow the 2-words-to-3-bytes rule, Done one cycle after the last byte.
   task automatic add_stream(input int t, input int n);
      int last;
      logic [11:0] a, b;
      start_arr[t] = 1'b1;
      nw_arr[t]    = 15'(n);
      for (int k = 0; k < n; k++) begin
         a = wq[k];
         for (int j = 0; j < 12; j++) ser_arr[t + 1 + 12*k + j] = a[11-j];
         exp_ws[t + 13 + 12*k] = 1'b1;
         exp_wd[t + 13 + 12*k] = a;
      end
      if (n == 0) begin
         exp_done[t + 1] = 1'b1;
         return;
      end
      last = 0;
      for (int k = 0; k < n; k += 2) begin
         int ta;
         ta = t + 13 + 12*k;
         a  = wq[k];
         exp_bs[ta + 1] = 1'b1;
         exp_bd[ta + 1] = a[11:4];
         if (k + 1 < n) begin
            b = wq[k+1];
            exp_bs[ta + 13] = 1'b1;
            exp_bd[ta + 13] = {a[3:0], b[11:8]};
            exp_bs[ta + 14] = 1'b1;
            exp_bd[ta + 14] = b[7:0];
            last = ta + 14;
         end else begin
            exp_bs[ta + 2] = 1'b1;
            exp_bd[ta + 2] = {a[3:0], 4'h0};
            last = ta + 2;
         end
      end
      for (int c = t + 1; c <= last; c++) exp_busy[c] = 1'b1;
      exp_done[last + 1] = 1'b1;
   endtask

   // A reset discards everything the model expected from cycle r onward.
   task automatic clear_from(input int r);
      for (int c = r; c < NCYC; c++) begin
         exp_ws[c] = 1'b0; exp_bs[c] = 1'b0;
         exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
      end
   endtask

   // drive inputs for the cycle just started
   always @(posedge Clock) begin
      #1;
      Reset    = !rst_arr[cyc];
      Start    = start_arr[cyc];
      NWords   = nw_arr[cyc];
      SerialIn = ser_arr[cyc];
   end

   // per-cycle comparison against the model, plus hand-computed literals
   always @(negedge Clock) begin
      chk("word_strb", 32'(WordStrb), 32'(exp_ws[cyc]));
      if (exp_ws[cyc]) chk("word_out", 32'(WordOut), 32'(exp_wd[cyc]));
      chk("byte_strb", 32'(ByteStrb), 32'(exp_bs[cyc]));
      if (exp_bs[cyc]) chk("byte_out", 32'(ByteOut), 32'(exp_bd[cyc]));
      chk("busy", 32'(Busy), 32'(exp_busy[cyc]));
      chk("done", 32'(Done), 32'(exp_done[cyc]));
      if (cyc >= 211 && cyc <= 1420) begin
         if (WordStrb) t6_words++;
         if (ByteStrb) t6_bytes++;
      end
      case (cyc)
         1:   begin chk("rst_word", 32'(WordOut), 32'h0); chk("rst_byte", 32'(ByteOut), 32'h0); end
         15:  chk("t1_word_lit", 32'(WordOut), 32'hA5C);
         16:  chk("t1_b0_lit", 32'(ByteOut), 32'hA5);
         17:  chk("t1_b1_lit", 32'(ByteOut), 32'hC0);
         18:  chk("t1_done_lit", 32'(Done), 32'h1);
         44:  chk("t2_b0_lit", 32'(ByteOut), 32'h12);
         56:  chk("t2_b1_lit", 32'(ByteOut), 32'h3A);
         57:  chk("t2_b2_lit", 32'(ByteOut), 32'hBC);
         71:  begin chk("t3_done_lit", 32'(Done), 32'h1); chk("t3_busy_lit", 32'(Busy), 32'h0); end
         130: chk("t4_b4_lit", 32'(ByteOut), 32'hE7);
         131: chk("t4_b5_lit", 32'(ByteOut), 32'hD1);
         170: chk("t5_pre_word_lit", 32'(WordOut), 32'h222);
         171: begin
                 chk("t5_rst_word_lit", 32'(WordOut), 32'h0);
                 chk("t5_rst_byte_lit", 32'(ByteOut), 32'h0);
                 chk("t5_rst_busy_lit", 32'(Busy), 32'h0);
              end
         193: chk("t5_word_lit", 32'(WordOut), 32'hFFF);
         194: chk("t5_b0_lit", 32'(ByteOut), 32'hFF);
         195: chk("t5_b1_lit", 32'(ByteOut), 32'hF0);
         1425: begin
                 chk("t6_word_count", 32'(t6_words), 32'd100);
                 chk("t6_byte_count", 32'(t6_bytes), 32'd150);
              end
         default: ;
      endcase
   end

   initial begin
      Reset = 1'b0; Start = 1'b0; NWords = '0; SerialIn = 1'b0;
      rst_arr[0] = 1'b1;
      rst_arr[1] = 1'b1;
      // 1: single word, odd count -> padded tail byte
      wq = '{12'hA5C};
      add_stream(2, 1);
      // 2: two words -> three bytes
      wq = '{12'h123, 12'hABC};
      add_stream(30, 2);
      // 3: zero words -> Done only
      wq.delete();
      add_stream(70, 0);
      // 4: four words, second Start mid word 2 must be ignored
      wq = '{12'h5A3, 12'h0F0, 12'hC3E, 12'h7D1};
      add_stream(80, 4);
      start_arr[110] = 1'b1;
      nw_arr[110]    = 15'd3;
      // 5: reset during word 3 of 5, then a fresh single-word transfer
      wq = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
      add_stream(140, 5);
      clear_from(171);
      rst_arr[171] = 1'b1;
      rst_arr[172] = 1'b1;
      wq = '{12'hFFF};
      add_stream(180, 1);
      // 6: long random transfer
      wq.delete();
      for (int i = 0; i < 100; i++) wq.push_back(12'($urandom));
      add_stream(210, 100);

      wait (cyc == ENDC);
      @(negedge Clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
